fibo_capture: RTL and testbench

Downstream capture stage for the 8-bit Fibonacci generator (`top_level`). It drives the generator's advance/hold input, accepts one term per advancing cycle into a small FIFO, and flags terms whose 8-bit sum wrapped. It presents the terms to the consumer over a valid/ready interface. It sits directly on the generator's `__out0`/`__in0` pair and shares its clock and reset.

---
 rtl/fibo_capture_if.sv | 26 ++
 rtl/fibo_capture.sv | 133 +++++++++++++
 tb/tb_fibo_capture.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/fibo_capture_if.sv
// fibo_capture_if: valid/ready term stream from the capture FIFO to its consumer.
//   out_data  : head-of-FIFO term (don't-care while out_valid is low)
//   out_wrap  : wrap flag of the head term
//   out_valid : FIFO not empty
//   out_ready : consumer accepts the head when high together with out_valid
// Modports: master = capture stage (drives the term), slave = consumer (drives ready).
interface fibo_capture_if;
  logic [7:0] out_data;
  logic       out_wrap;
  logic       out_valid;
  logic       out_ready;

  modport master (
    output out_data,
    output out_wrap,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_wrap,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/fibo_capture.sv
// fibo_capture: capture stage behind the 8-bit Fibonacci generator.
// Drives the generator's hold input, stores one term per advancing cycle in a FIFO,
// flags terms whose 8-bit sum wrapped and presents them over a valid/ready stream.
//
// Ports:
//   clk      : clock, rising edge
//   rst      : asynchronous reset, active low
//   cap_en   : capture enable; 0 holds the generator
//   in_data  : generator output term
//   in_hold  : generator hold (1 holds, 0 advances)
//   term_cnt : terms accepted since reset, wraps modulo 2^CNT_W
//   out_if   : term stream to the consumer (master side)
//
// Optional feature: define FIBO_CAPTURE_WRAP_FLAG_EN to build the wrap detector and
// the extra storage bit. Without it out_wrap is tied to 0.
module fibo_capture #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cap_en,
  input  logic [7:0]           in_data,
  output logic                 in_hold,
  output logic [CNT_W-1:0]     term_cnt,
  fibo_capture_if.master       out_if
);

  localparam int unsigned AW = $clog2(DEPTH);
`ifdef FIBO_CAPTURE_WRAP_FLAG_EN
  localparam int unsigned SW = 9;
`else
  localparam int unsigned SW = 8;
`endif

  // Pointers carry one extra lap bit to tell full from empty.
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] term_cnt_q, term_cnt_d;
  logic [SW-1:0]    mem_q [DEPTH];
  logic [SW-1:0]    wr_entry;
  logic [SW-1:0]    rd_entry;

  logic full, empty, push, pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // Hold depends only on registered full and cap_en: no path from out_ready, so a pop
  // from full frees the slot for the next cycle, not this one.
  assign in_hold = !cap_en || full;
  assign push    = !in_hold;
  assign pop     = !empty && out_if.out_ready;

`ifdef FIBO_CAPTURE_WRAP_FLAG_EN
  logic [7:0] prev_q, prev_d;
  logic       have_prev_q, have_prev_d;
  logic       wrap;

  // A decrease between consecutive captured terms means the 8-bit sum overflowed.
  assign wrap     = have_prev_q && (in_data < prev_q);
  assign wr_entry = {wrap, in_data};

  always_comb begin
    prev_d      = prev_q;
    have_prev_d = have_prev_q;
    if (push) begin
      prev_d      = in_data;
      have_prev_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_q      <= 8'd0;
      have_prev_q <= 1'b0;
    end else begin
      prev_q      <= prev_d;
      have_prev_q <= have_prev_d;
    end
  end
`else
  assign wr_entry = in_data;
`endif

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    term_cnt_d = term_cnt_q;
    if (push) begin
      wr_ptr_d   = wr_ptr_q + 1'b1;
      term_cnt_d = term_cnt_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      term_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      term_cnt_q <= term_cnt_d;
    end
  end

  // Storage needs no reset: contents are only observed behind valid pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wr_entry;
    end
  end

  assign rd_entry = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    out_if.out_data  = rd_entry[7:0];
`ifdef FIBO_CAPTURE_WRAP_FLAG_EN
    out_if.out_wrap  = rd_entry[8];
`else
    out_if.out_wrap  = 1'b0;
`endif
    out_if.out_valid = !empty;
  end

  assign term_cnt = term_cnt_q;

endmodule

// File: tb/tb_fibo_capture.sv
// tb_fibo_capture: directed bench for fibo_capture driven by a behavioural model of the
// 8-bit Fibonacci generator. Expected terms are a hand-computed table.
module tb_fibo_capture;

  logic        clk;
  logic        rst;
  logic        cap_en;
  logic [7:0]  in_data;
  logic        in_hold;
  logic [15:0] term_cnt;

  fibo_capture_if out_if ();

  fibo_capture #(
    .DEPTH (8),
    .CNT_W (16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cap_en   (cap_en),
    .in_data  (in_data),
    .in_hold  (in_hold),
    .term_cnt (term_cnt),
    .out_if   (out_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Generator model: presents a, advances (a,b) <= (b, a+b) when not held.
  logic [7:0] gen_a, gen_b;
  assign in_data = gen_a;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gen_a <= 8'd0;
      gen_b <= 8'd1;
    end else if (!in_hold) begin
      gen_a <= gen_b;
      gen_b <= gen_a + gen_b;
    end
  end

  logic [7:0] exp_seq [15];
  int n_checks;
  int n_errors;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one edge, then settle 1 time unit so outputs and inputs are off the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic en, input logic rdy);
    rst              = 1'b0;
    cap_en           = en;
    out_if.out_ready = rdy;
    tick();
    tick();
    rst = 1'b1;
  endtask

  function automatic logic exp_wrap(input int idx);
`ifdef FIBO_CAPTURE_WRAP_FLAG_EN
    return (idx == 14);
`else
    return 1'b0;
`endif
  endfunction

  initial begin
    int n;
    logic c;
    n_checks = 0;
    n_errors = 0;
    exp_seq  = '{8'd0, 8'd1, 8'd1, 8'd2, 8'd3, 8'd5, 8'd8, 8'd13, 8'd21, 8'd34,
                 8'd55, 8'd89, 8'd144, 8'd233, 8'd121};

    // Reset state, including in_hold following cap_en while in reset.
    rst = 1'b0; cap_en = 1'b0; out_if.out_ready = 1'b0;
    #2;
    check("rst_valid", out_if.out_valid, 0);
    check("rst_cnt", term_cnt, 0);
    check("rst_hold_en0", in_hold, 1);
    cap_en = 1'b1;
    #1;
    check("rst_hold_en1", in_hold, 0);

    // Free-running capture with a consumer that is always ready.
    do_reset(1'b1, 1'b1);
    for (int i = 0; i < 15; i++) begin
      tick();
      check($sformatf("seq_valid[%0d]", i), out_if.out_valid, 1);
      check($sformatf("seq_data[%0d]", i), out_if.out_data, exp_seq[i]);
      check($sformatf("seq_wrap[%0d]", i), out_if.out_wrap, exp_wrap(i));
    end
    check("seq_cnt", term_cnt, 15);

    // Consumer stalled: FIFO fills after 8 pushes and the generator is held.
    do_reset(1'b1, 1'b0);
    for (int i = 0; i < 7; i++) tick();
    check("fill7_hold", in_hold, 0);
    tick();
    check("fill_cnt", term_cnt, 8);
    check("fill_hold", in_hold, 1);
    for (int i = 0; i < 3; i++) tick();
    check("held_cnt", term_cnt, 8);
    check("held_data_in", in_data, 21);
    check("held_hold", in_hold, 1);
    check("held_head", out_if.out_data, 0);

    // One-cycle pop from full: head advances, slot refilled on the next edge.
    out_if.out_ready = 1'b1;
    tick();
    out_if.out_ready = 1'b0;
    check("pop_head", out_if.out_data, 1);
    check("pop_hold", in_hold, 0);
    check("pop_cnt", term_cnt, 8);
    tick();
    check("refill_cnt", term_cnt, 9);
    check("refill_hold", in_hold, 1);

    // Drain with capture disabled: contents must be 1,1,2,3,5,8,13,21 without repeats.
    cap_en = 1'b0;
    out_if.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("drain_valid[%0d]", i), out_if.out_valid, 1);
      check($sformatf("drain_data[%0d]", i), out_if.out_data, exp_seq[i+1]);
      tick();
    end
    check("drain_empty", out_if.out_valid, 0);
    check("drain_cnt", term_cnt, 9);

    // cap_en pattern 1,0,0,1: terms accepted only with cap_en=1 and stay contiguous.
    do_reset(1'b0, 1'b1);
    n = 0;
    for (int i = 0; i < 12; i++) begin
      c = ((i % 4) == 0) || ((i % 4) == 3);
      cap_en = c;
      #1;
      check($sformatf("tog_hold[%0d]", i), in_hold, !c);
      tick();
      if (c) begin
        check($sformatf("tog_valid[%0d]", i), out_if.out_valid, 1);
        check($sformatf("tog_data[%0d]", i), out_if.out_data, exp_seq[n]);
        n++;
      end else begin
        check($sformatf("tog_valid[%0d]", i), out_if.out_valid, 0);
      end
      check($sformatf("tog_cnt[%0d]", i), term_cnt, n);
    end

    // Asynchronous reset with 5 terms buffered, then restart without a stale wrap flag.
    do_reset(1'b1, 1'b0);
    for (int i = 0; i < 5; i++) tick();
    check("pre_rst_cnt", term_cnt, 5);
    check("pre_rst_valid", out_if.out_valid, 1);
    rst = 1'b0;
    #1;
    check("mid_rst_valid", out_if.out_valid, 0);
    check("mid_rst_cnt", term_cnt, 0);
    tick();
    rst = 1'b1;
    tick();
    check("post_rst_valid", out_if.out_valid, 1);
    check("post_rst_data", out_if.out_data, 0);
    check("post_rst_wrap", out_if.out_wrap, 0);
    check("post_rst_cnt", term_cnt, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
